systemne_st_to_mem_writer: RTL and testbench

- Upstream feeder for the system's 8192x32 single-port on-chip memory.
- Accepts one Avalon-ST byte-stream packet and packs bytes little-endian into 32-bit words.
- Writes each word sequentially through a write-only Avalon-MM master into the memory's s1 port, starting at a programmable base word address.
- The memory has no waitrequest, so every write completes in one cycle.

---
 rtl/systemne_st2mem_pkg.sv | 25 ++
 rtl/systemne_byte_packer.sv | 64 ++++++
 rtl/systemne_st_to_mem_writer.sv | 115 +++++++++++
 tb/tb_systemne_st_to_mem_writer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systemne_st2mem_pkg.sv
// Shared types and constants for the Avalon-ST to on-chip memory writer.
package systemne_st2mem_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOP,
    PACK,
    WRITE,
    DRAIN,
    DONE
  } state_t;

  // Number of valid byte lanes in a word, used to advance the byte counter.
  function automatic logic [LANE_W:0] lane_count(input logic [BYTES_PER_WORD-1:0] be);
    logic [LANE_W:0] n;
    n = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) n = n + {{LANE_W{1'b0}}, be[i]};
    return n;
  endfunction

endpackage

// File: rtl/systemne_byte_packer.sv
// Packs accepted stream bytes little-endian into a word and holds the last
// completed word (data, byteenable, end-of-packet flag) until the next one.
module systemne_byte_packer
  import systemne_st2mem_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      accept,
  input  logic [7:0]                in_byte,
  input  logic                      eop,
  input  logic                      clear,
  output logic [WORD_W-1:0]         word_data,
  output logic [BYTES_PER_WORD-1:0] word_be,
  output logic                      word_done,
  output logic                      last
);

  logic [LANE_W-1:0]         lane;
  logic [WORD_W-1:0]         acc_data;
  logic [BYTES_PER_WORD-1:0] acc_be;
  logic [WORD_W-1:0]         merged_data;
  logic [BYTES_PER_WORD-1:0] merged_be;

  always_comb begin
    merged_data                = acc_data;
    merged_data[8*lane +: 8]   = in_byte;
    merged_be                  = acc_be | (BYTES_PER_WORD'(1) << lane);
  end

  assign word_done = accept & ((lane == LANE_W'(BYTES_PER_WORD - 1)) | eop);

  // NOTE: the data registers are small flops, not a RAM, so they take the
  // async reset like everything else; outputs must read 0 while in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane      <= '0;
      acc_data  <= '0;
      acc_be    <= '0;
      word_data <= '0;
      word_be   <= '0;
      last      <= 1'b0;
    end else if (clear) begin
      lane     <= '0;
      acc_data <= '0;
      acc_be   <= '0;
      last     <= 1'b0;
    end else if (accept) begin
      if (word_done) begin
        // Publish the finished word; the accumulator restarts at lane 0.
        word_data <= merged_data;
        word_be   <= merged_be;
        acc_data  <= '0;
        acc_be    <= '0;
        lane      <= '0;
        last      <= eop;
      end else begin
        acc_data <= merged_data;
        acc_be   <= merged_be;
        lane     <= lane + LANE_W'(1);
      end
    end
  end

endmodule

// File: rtl/systemne_st_to_mem_writer.sv
// Writes one Avalon-ST byte packet into the 8192x32 on-chip memory as packed
// little-endian words at consecutive addresses from a programmable base.
module systemne_st_to_mem_writer
  import systemne_st2mem_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int LEN_W  = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [LEN_W-1:0]          max_words,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_startofpacket,
  input  logic                      in_endofpacket,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [WORD_W-1:0]         mem_writedata,
  output logic [BYTES_PER_WORD-1:0] mem_byteenable,
  output logic                      mem_chipselect,
  output logic                      mem_write,
  output logic                      mem_clken,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [LEN_W-1:0]          word_count,
  output logic [LEN_W+1:0]          byte_count
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  max_q;
  logic [LEN_W-1:0]  word_count_inc;
  logic              hs, start_ok, pk_accept, pk_done, pk_last;

  assign hs             = in_valid & in_ready;
  assign start_ok       = start & ((state == IDLE) | (state == DONE));
  assign pk_accept      = hs & ((state == PACK) | ((state == WAIT_SOP) & in_startofpacket));
  assign word_count_inc = word_count + LEN_W'(1);

  systemne_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .accept    (pk_accept),
    .in_byte   (in_data),
    .eop       (in_endofpacket),
    .clear     (start_ok),
    .word_data (mem_writedata),
    .word_be   (mem_byteenable),
    .word_done (pk_done),
    .last      (pk_last)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: next state defaults to the current state first, so no latch forms.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start_ok) state_nxt = (max_words == '0) ? DONE : WAIT_SOP;
      WAIT_SOP:   if (pk_done) state_nxt = WRITE;
                  else if (pk_accept) state_nxt = PACK;
      PACK:       if (pk_done) state_nxt = WRITE;
      WRITE:      if (pk_last) state_nxt = DONE;
                  else if (word_count_inc == max_q) state_nxt = DRAIN;
                  else state_nxt = PACK;
      DRAIN:      if (hs && in_endofpacket) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready       = (state == WAIT_SOP) | (state == PACK) | (state == DRAIN);
    mem_write      = (state == WRITE);
    mem_chipselect = (state == WRITE);
    busy           = (state == WAIT_SOP) | (state == PACK) | (state == WRITE) | (state == DRAIN);
    done           = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q      <= '0;
      max_q       <= '0;
      word_count  <= '0;
      byte_count  <= '0;
      overflow    <= 1'b0;
      mem_address <= '0;
      mem_clken   <= 1'b0;
    end else begin
      mem_clken <= 1'b1;
      if (start_ok) begin
        base_q     <= base_addr;
        max_q      <= max_words;
        word_count <= '0;
        byte_count <= '0;
        overflow   <= 1'b0;
      end
      // Address is captured with the completing byte so it is stable in WRITE.
      if (pk_done) mem_address <= base_q + word_count[ADDR_W-1:0];
      if (state == WRITE) begin
        word_count <= word_count_inc;
        byte_count <= byte_count + (LEN_W+2)'(lane_count(mem_byteenable));
      end
      if ((state == DRAIN) && hs) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_systemne_st_to_mem_writer.sv
// Directed bench: packet-level reference model plus per-write compare monitor.
module tb_systemne_st_to_mem_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] base_addr;
  logic [13:0] max_words;
  logic [7:0]  in_data;
  logic        in_valid, in_ready, in_startofpacket, in_endofpacket;
  logic [12:0] mem_address;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken, busy, done, overflow;
  logic [13:0] word_count;
  logic [15:0] byte_count;

  always #5 clk = ~clk;

  systemne_st_to_mem_writer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .max_words(max_words),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .mem_address(mem_address), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_clken(mem_clken),
    .busy(busy), .done(done), .overflow(overflow), .word_count(word_count), .byte_count(byte_count)
  );

  typedef struct packed {
    logic [12:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  wr_t  exp_q[$];
  wr_t  got_q[$];
  int   got_cyc[$];
  logic [7:0] pd[$];
  bit   ps[$];
  bit   pe[$];
  int   exp_wc, exp_bc, exp_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Compare every memory write against the model's expected write queue.
  always @(negedge clk) begin
    if (!reset && mem_write) begin
      wr_t w, e;
      w = {mem_address, mem_writedata, mem_byteenable};
      got_q.push_back(w);
      got_cyc.push_back(cyc);
      check("chipselect_with_write", 32'(mem_chipselect), 32'd1);
      check("in_ready_low_in_write", 32'(in_ready), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", mem_address, mem_writedata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(w.addr), 32'(e.addr));
        check("write_data", w.data, e.data);
        check("write_be", 32'(w.be), 32'(e.be));
      end
    end
  end

  task automatic add(input logic [7:0] d, input bit s, input bit e);
    pd.push_back(d); ps.push_back(s); pe.push_back(e);
  endtask

  task automatic packet(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) add(first + 8'(i), i == 0, i == n - 1);
  endtask

  task automatic new_test();
    pd.delete(); ps.delete(); pe.delete(); got_q.delete(); got_cyc.delete(); exp_q.delete();
  endtask

  // Packet-level behaviour: skip to SOP, 4 bytes or EOP per word, drain past budget.
  task automatic run_model(input logic [12:0] base, input int max);
    int ph, lane;
    logic [31:0] word;
    logic [3:0] be;
    exp_wc = 0; exp_bc = 0; exp_ovf = 0;
    ph = 0; lane = 0; word = 0; be = 0;
    if (max == 0) return;
    for (int i = 0; i < pd.size(); i++) begin
      if (ph == 2) begin
        exp_ovf = 1;
        if (pe[i]) ph = 3;
      end else if (ph == 1 || (ph == 0 && ps[i])) begin
        ph = 1;
        word = word | (32'(pd[i]) << (8 * lane));
        be = be | (4'd1 << lane);
        lane++;
        if (lane == 4 || pe[i]) begin
          exp_q.push_back({13'(int'(base) + exp_wc), word, be});
          exp_wc++;
          exp_bc += lane;
          word = 0; be = 0; lane = 0;
          if (pe[i]) ph = 3;
          else if (exp_wc == max) ph = 2;
        end
      end
    end
  endtask

  task automatic do_start(input logic [12:0] base, input logic [13:0] max);
    @(negedge clk);
    base_addr = base; max_words = max; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_all(input int start_at);
    int k;
    for (int i = 0; i < pd.size(); i++) begin
      in_data = pd[i]; in_startofpacket = ps[i]; in_endofpacket = pe[i];
      in_valid = 1'b1; start = (i == start_at);
      k = 0;
      while (!in_ready && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (!in_ready) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: got in_ready 0 at byte %0d, expected 1", i);
        in_valid = 1'b0; start = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
  endtask

  task automatic finish_test();
    int k;
    k = 0;
    while (!done && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("done", 32'(done), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
    check("word_count", 32'(word_count), 32'(exp_wc));
    check("byte_count", 32'(byte_count), 32'(exp_bc));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; max_words = '0;
    in_data = '0; in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
    #1;
    check("rst_clken", 32'(mem_clken), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", mem_writedata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("clken_after_reset", 32'(mem_clken), 32'd1);
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Two full words at base 0x010, back-to-back bytes.
    new_test(); packet(8, 8'h01); run_model(13'h010, 4);
    do_start(13'h010, 14'd4); send_all(-1); finish_test();
    check("t1_nwrites", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("t1_w0_addr", 32'(got_q[0].addr), 32'h010);
      check("t1_w0_data", got_q[0].data, 32'h04030201);
      check("t1_w1_addr", 32'(got_q[1].addr), 32'h011);
      check("t1_w1_data", got_q[1].data, 32'h08070605);
      check("t1_w1_be", 32'(got_q[1].be), 32'hF);
      check("t1_write_spacing", 32'(got_cyc[1] - got_cyc[0]), 32'd5);
    end
    check("t1_bytes_lit", 32'(byte_count), 32'd8);

    // Partial last word.
    new_test(); packet(6, 8'h01); run_model(13'h000, 4);
    do_start(13'h000, 14'd4); send_all(-1); finish_test();
    if (got_q.size() == 2) begin
      check("t2_w1_addr", 32'(got_q[1].addr), 32'h001);
      check("t2_w1_data", got_q[1].data, 32'h00000605);
      check("t2_w1_be", 32'(got_q[1].be), 32'h3);
    end
    check("t2_bytes_lit", 32'(byte_count), 32'd6);

    // Budget of one word: remainder drained, overflow flagged.
    new_test(); packet(9, 8'h01); run_model(13'h040, 1);
    do_start(13'h040, 14'd1); send_all(-1); finish_test();
    check("t3_nwrites", 32'(got_q.size()), 32'd1);
    check("t3_ovf_lit", 32'(overflow), 32'd1);
    check("t3_words_lit", 32'(word_count), 32'd1);
    check("t3_bytes_lit", 32'(byte_count), 32'd4);

    // Address wrap; EOP coincides with budget exhaustion.
    new_test(); packet(8, 8'h31); run_model(13'h1FFF, 2);
    do_start(13'h1FFF, 14'd2); send_all(-1); finish_test();
    if (got_q.size() == 2) begin
      check("t4_w0_addr", 32'(got_q[0].addr), 32'h1FFF);
      check("t4_w1_addr", 32'(got_q[1].addr), 32'h0000);
    end
    check("t4_ovf_lit", 32'(overflow), 32'd0);

    // Junk before SOP; a start pulse during PACK with new base must be ignored.
    new_test();
    add(8'h11, 0, 0); add(8'h22, 0, 0); add(8'h33, 0, 0);
    packet(4, 8'hA1); run_model(13'h020, 4);
    do_start(13'h020, 14'd4);
    base_addr = 13'h055; max_words = 14'd1;
    send_all(4); finish_test();
    check("t5_nwrites", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) begin
      check("t5_w0_addr", 32'(got_q[0].addr), 32'h020);
      check("t5_w0_data", got_q[0].data, 32'hA4A3A2A1);
    end

    // One-byte packet.
    new_test(); packet(1, 8'h5A); run_model(13'h100, 3);
    do_start(13'h100, 14'd3); send_all(-1); finish_test();
    if (got_q.size() == 1) begin
      check("t6_w0_data", got_q[0].data, 32'h0000005A);
      check("t6_w0_be", 32'(got_q[0].be), 32'h1);
    end

    // Zero budget: straight back to DONE, counters cleared, no write.
    new_test(); run_model(13'h005, 0);
    do_start(13'h005, 14'd0); finish_test();
    check("t7_nwrites", 32'(got_q.size()), 32'd0);
    check("t7_words_lit", 32'(word_count), 32'd0);

    // Asynchronous reset mid-word.
    new_test(); packet(4, 8'hC1);
    do_start(13'h200, 14'd4);
    pd = pd[0:1]; ps = ps[0:1]; pe = pe[0:1];
    send_all(-1);
    reset = 1'b1;
    #1;
    check("ar_in_ready", 32'(in_ready), 32'd0);
    check("ar_write", 32'(mem_write), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_done", 32'(done), 32'd0);
    check("ar_words", 32'(word_count), 32'd0);
    check("ar_bytes", 32'(byte_count), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("ar_nwrites", 32'(got_q.size()), 32'd0);
    check("ar_idle_busy", 32'(busy), 32'd0);
    check("ar_idle_ready", 32'(in_ready), 32'd0);
    check("ar_idle_done", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
